ingress_port_arbiter: RTL and testbench

INGRESS_PORT_ARBITER -- requirements
Module: ingress_port_arbiter

---
 rtl/ingress_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ingress_port_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_port_arbiter.sv
// ingress_port_arbiter
//   Merges four AXI-Stream ingress ports into one stream toward the switch
//   fabric. Arbitration is round-robin at frame granularity, so beats of
//   different frames never interleave. Frames longer than MAX_BEATS are cut:
//   the last forwarded beat is marked tlast+tuser and the rest of the frame
//   is dropped. A saturating counter records how many frames were cut.
//
// Ports
//   aclk            fabric clock, rising edge
//   areset_n        synchronous active-low reset
//   s_tvalid[3:0]   per-port beat valid (bit i = port i)
//   s_tready[3:0]   per-port beat ready
//   s_tdata[127:0]  per-port data, port i at [32i+31:32i]
//   s_tkeep[15:0]   per-port byte enables, port i at [4i+3:4i]
//   s_tuser[3:0]    per-port error flag
//   s_tlast[3:0]    per-port end of frame
//   m_t*            merged output stream (m_tready is the only input)
//   m_tid[1:0]      source port of the current output beat
//   trunc_count     saturating count of truncated frames
module ingress_port_arbiter #(
  parameter int MAX_BEATS = 388
) (
  input  logic         aclk,
  input  logic         areset_n,
  input  logic [3:0]   s_tvalid,
  output logic [3:0]   s_tready,
  input  logic [127:0] s_tdata,
  input  logic [15:0]  s_tkeep,
  input  logic [3:0]   s_tuser,
  input  logic [3:0]   s_tlast,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [31:0]  m_tdata,
  output logic [3:0]   m_tkeep,
  output logic         m_tuser,
  output logic         m_tlast,
  output logic [1:0]   m_tid,
  output logic [15:0]  trunc_count
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_FORWARD, S_DISCARD} state_t;

  state_t           r_state, w_state_next;
  logic [1:0]       r_grant, w_grant_next;
  logic [1:0]       r_rr_ptr, w_rr_ptr_next;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_next;
  logic [15:0]      r_trunc_count, w_trunc_count_next;

  logic             r_m_tvalid;
  logic [31:0]      r_m_tdata;
  logic [3:0]       r_m_tkeep;
  logic             r_m_tuser;
  logic             r_m_tlast;
  logic [1:0]       r_m_tid;

  logic [31:0]      w_port_data [4];
  logic [3:0]       w_port_keep [4];
  logic [31:0]      w_sel_data;
  logic [3:0]       w_sel_keep;
  logic             w_sel_valid, w_sel_user, w_sel_last;
  logic [3:0]       w_tready;
  logic             w_out_free, w_accept, w_at_limit, w_trunc;
  logic [1:0]       w_pick;

  for (genvar gi = 0; gi < 4; gi++) begin : g_port
    assign w_port_data[gi] = s_tdata[32*gi +: 32];
    assign w_port_keep[gi] = s_tkeep[4*gi +: 4];
  end

  assign w_sel_data  = w_port_data[r_grant];
  assign w_sel_keep  = w_port_keep[r_grant];
  assign w_sel_valid = s_tvalid[r_grant];
  assign w_sel_user  = s_tuser[r_grant];
  assign w_sel_last  = s_tlast[r_grant];

  // The output register can take a new beat when empty or being drained.
  assign w_out_free = !r_m_tvalid || m_tready;

  // Ready is forced low while reset is held so nothing is consumed upstream.
  always_comb begin
    w_tready = '0;
    if (areset_n) begin
      case (r_state)
        S_FORWARD: w_tready[r_grant] = w_out_free;
        S_DISCARD: w_tready[r_grant] = 1'b1;
        default:   w_tready = '0;
      endcase
    end
  end

  assign s_tready   = w_tready;
  assign w_accept   = w_sel_valid && w_tready[r_grant];
  assign w_at_limit = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_trunc    = (r_state == S_FORWARD) && w_accept && w_at_limit && !w_sel_last;

  // First requesting port at or after rr_ptr. Scanning offsets downward lets
  // the smallest offset win without a found flag.
  always_comb begin
    w_pick = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (s_tvalid[r_rr_ptr + 2'(k)]) begin
        w_pick = r_rr_ptr + 2'(k);
      end
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_grant_next       = r_grant;
    w_rr_ptr_next      = r_rr_ptr;
    w_beat_cnt_next    = r_beat_cnt;
    w_trunc_count_next = r_trunc_count;
    case (r_state)
      S_IDLE: begin
        if (|s_tvalid) begin
          w_grant_next    = w_pick;
          w_beat_cnt_next = '0;
          w_state_next    = S_FORWARD;
        end
      end
      S_FORWARD: begin
        if (w_accept) begin
          if (w_sel_last) begin
            w_rr_ptr_next   = r_grant + 2'd1;
            w_beat_cnt_next = '0;
            w_state_next    = S_IDLE;
          end else if (w_at_limit) begin
            w_beat_cnt_next = '0;
            w_state_next    = S_DISCARD;
            if (r_trunc_count != 16'hFFFF) begin
              w_trunc_count_next = r_trunc_count + 16'd1;
            end
          end else begin
            w_beat_cnt_next = r_beat_cnt + CNT_W'(1);
          end
        end
      end
      S_DISCARD: begin
        if (w_accept && w_sel_last) begin
          w_rr_ptr_next = r_grant + 2'd1;
          w_state_next  = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_beat_cnt    <= '0;
      r_trunc_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_grant       <= w_grant_next;
      r_rr_ptr      <= w_rr_ptr_next;
      r_beat_cnt    <= w_beat_cnt_next;
      r_trunc_count <= w_trunc_count_next;
    end
  end

  // Output register: loads only beats forwarded in FORWARD; discarded beats
  // never reach it. Holds its contents while stalled.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tid    <= '0;
    end else if ((r_state == S_FORWARD) && w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_sel_data;
      r_m_tkeep  <= w_sel_keep;
      r_m_tuser  <= w_sel_user || w_trunc;
      r_m_tlast  <= w_sel_last || w_trunc;
      r_m_tid    <= r_grant;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tvalid    = r_m_tvalid;
  assign m_tdata     = r_m_tdata;
  assign m_tkeep     = r_m_tkeep;
  assign m_tuser     = r_m_tuser;
  assign m_tlast     = r_m_tlast;
  assign m_tid       = r_m_tid;
  assign trunc_count = r_trunc_count;

endmodule

// File: tb/tb_ingress_port_arbiter.sv
// tb_ingress_port_arbiter
//   Self-checking bench for ingress_port_arbiter (MAX_BEATS = 4). Per-port
//   source queues feed randomized valid patterns; a reference model turns
//   every observed upstream handshake into the beat expected on the output
//   one cycle later (applying the truncation rule), and the output is
//   compared every cycle against the head of that expected queue.
module tb_ingress_port_arbiter;

  localparam int MAXB = 4;

  logic         aclk = 1'b0;
  logic         areset_n;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tready;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic [3:0]   s_tuser;
  logic [3:0]   s_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;
  logic         m_tuser;
  logic         m_tlast;
  logic [1:0]   m_tid;
  logic [15:0]  trunc_count;

  always #5 aclk = ~aclk;

  ingress_port_arbiter #(.MAX_BEATS(MAXB)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tid(m_tid), .trunc_count(trunc_count)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        user;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [1:0]  tid;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        user;
    logic        last;
  } obeat_t;

  beat_t   src_q [4][$];
  obeat_t  out_q [$];
  logic [3:0] vld_hold;
  int      beat_n [4];
  bit      discarding [4];
  int      cur_port;
  int      exp_trunc;

  logic [41:0] obs_vec, exp_vec;
  logic        snap_take, snap_tid_last, snap_user;
  logic [1:0]  snap_tid;

  int n_run  = 0;
  int n_fail = 0;

  task automatic add_frame(input int p, input int len, input int umode);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.keep = 4'($urandom);
      b.last = (i == len - 1);
      case (umode)
        0:       b.user = 1'b0;
        1:       b.user = (i == len - 1);
        default: b.user = 1'($urandom_range(1));
      endcase
      src_q[p].push_back(b);
    end
  endtask

  task automatic drive_ports();
    for (int p = 0; p < 4; p++) begin
      s_tvalid[p] = vld_hold[p];
      if (src_q[p].size() > 0) begin
        s_tdata[32*p +: 32] = src_q[p][0].data;
        s_tkeep[4*p +: 4]   = src_q[p][0].keep;
        s_tuser[p]          = src_q[p][0].user;
        s_tlast[p]          = src_q[p][0].last;
      end else begin
        s_tdata[32*p +: 32] = '0;
        s_tkeep[4*p +: 4]   = '0;
        s_tuser[p]          = 1'b0;
        s_tlast[p]          = 1'b0;
      end
    end
  endtask

  task automatic reset_model();
    out_q.delete();
    cur_port  = -1;
    exp_trunc = 0;
    for (int p = 0; p < 4; p++) begin
      beat_n[p]     = 0;
      discarding[p] = 1'b0;
    end
  endtask

  // Behavioural rule: an accepted beat is forwarded unless the frame is
  // being dropped; the MAX_BEATS-th beat without tlast is forced to
  // tlast=tuser=1 and the remainder of that frame is dropped.
  task automatic model_accept(input int p);
    beat_t  b;
    obeat_t o;
    b = src_q[p].pop_front();
    vld_hold[p] = 1'b0;
    if (!discarding[p]) begin
      o.tid  = 2'(p);
      o.data = b.data;
      o.keep = b.keep;
      if (beat_n[p] == MAXB - 1 && !b.last) begin
        o.user = 1'b1;
        o.last = 1'b1;
        discarding[p] = 1'b1;
        if (exp_trunc < 65535) exp_trunc++;
      end else begin
        o.user = b.user;
        o.last = b.last;
      end
      out_q.push_back(o);
      beat_n[p]++;
    end
    if (b.last) begin
      beat_n[p]     = 0;
      discarding[p] = 1'b0;
      cur_port      = -1;
    end else begin
      cur_port = p;
    end
  endtask

  // One clock cycle: drive inputs, snapshot observed/expected, then advance
  // the model with whatever handshakes happen at the coming edge.
  task automatic step(input int vprob, input int rprob);
    int acc_cnt;
    int acc_port;
    bit viol;
    @(negedge aclk);
    m_tready = ($urandom_range(99) < rprob);
    for (int p = 0; p < 4; p++) begin
      if (!vld_hold[p] && src_q[p].size() > 0 && $urandom_range(99) < vprob)
        vld_hold[p] = 1'b1;
    end
    drive_ports();
    #1;
    acc_cnt  = 0;
    acc_port = 0;
    for (int p = 0; p < 4; p++) begin
      if (s_tvalid[p] && s_tready[p]) begin
        acc_cnt++;
        acc_port = p;
      end
    end
    viol = (acc_cnt > 1) || (acc_cnt == 1 && cur_port >= 0 && cur_port != acc_port);
    obs_vec = {viol, (m_tvalid ? {1'b1, m_tid, m_tdata, m_tkeep, m_tuser, m_tlast} : 41'b0)};
    exp_vec = {1'b0, ((out_q.size() > 0) ? {1'b1, out_q[0]} : 41'b0)};
    snap_take     = m_tvalid && m_tready;
    snap_tid      = m_tid;
    snap_tid_last = m_tlast;
    snap_user     = m_tuser;
    @(posedge aclk);
    if (out_q.size() > 0 && m_tready) void'(out_q.pop_front());
    if (acc_cnt == 1) model_accept(acc_port);
  endtask

  function automatic bit quiet();
    quiet = (out_q.size() == 0);
    for (int p = 0; p < 4; p++) if (src_q[p].size() != 0) quiet = 1'b0;
  endfunction

  task automatic pulse_reset();
    @(negedge aclk);
    areset_n = 1'b0;
    vld_hold = '0;
    drive_ports();
    @(posedge aclk);
    reset_model();
    @(negedge aclk);
    areset_n = 1'b1;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    s_tvalid = 4'hF;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tuser  = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    vld_hold = '0;
    reset_model();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    #1;
    n_run++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tuser, m_tlast, m_tid, trunc_count, s_tready} !== 61'b0) begin
      n_fail++;
      $display("FAIL reset_state: m_tvalid=%0b m_tid=%0d trunc=%0d s_tready=%b, required all zero",
               m_tvalid, m_tid, trunc_count, s_tready);
    end
    s_tvalid = '0;
    areset_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_single_frame();
    int beats = 0;
    int last_at = -1;
    add_frame(2, 3, 0);
    for (int c = 0; c < 200 && !quiet(); c++) begin
      step(100, 100);
      n_run++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL single_beat: got=%h required=%h", obs_vec, exp_vec);
      end
      if (snap_take) begin
        beats++;
        if (snap_tid_last) last_at = beats;
      end
    end
    n_run++;
    if (beats !== 3 || last_at !== 3) begin
      n_fail++;
      $display("FAIL single_count: beats=%0d last_at=%0d, required 3 and 3", beats, last_at);
    end
    $display("[TB] single frame port 2: %0d beats", beats);
  endtask

  task automatic test_fairness();
    int order [$];
    pulse_reset();
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < 4; p++) add_frame(p, 2, 0);
    for (int c = 0; c < 400 && !quiet(); c++) begin
      step(100, 100);
      n_run++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL fair_beat: got=%h required=%h", obs_vec, exp_vec);
      end
      if (snap_take && snap_tid_last) order.push_back(int'(snap_tid));
    end
    n_run++;
    if (order.size() !== 12) begin
      n_fail++;
      $display("FAIL fair_frames: got %0d frames, required 12", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      n_run++;
      if (order[k] !== (k % 4)) begin
        n_fail++;
        $display("FAIL fair_order: frame %0d from port %0d, required port %0d", k, order[k], k % 4);
      end
    end
    $display("[TB] fairness: %0d frames", order.size());
  endtask

  task automatic test_backpressure();
    int pat [6] = '{100, 100, 100, 0, 0, 100};
    int beats = 0;
    add_frame(1, 4, 0);
    for (int c = 0; c < 200 && !quiet(); c++) begin
      step(100, (c < 6) ? pat[c] : 100);
      n_run++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bp_beat: cycle %0d got=%h required=%h", c, obs_vec, exp_vec);
      end
      if (snap_take) beats++;
    end
    n_run++;
    if (beats !== 4) begin
      n_fail++;
      $display("FAIL bp_count: beats=%0d, required 4", beats);
    end
    $display("[TB] backpressure: %0d beats", beats);
  endtask

  task automatic test_truncation();
    int t0 = int'(trunc_count);
    int beats = 0;
    int lasts = 0;
    add_frame(0, 6, 0);
    add_frame(0, 4, 0);
    for (int c = 0; c < 200 && !quiet(); c++) begin
      step(100, 100);
      n_run++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL trunc_beat: got=%h required=%h", obs_vec, exp_vec);
      end
      if (snap_take) begin
        beats++;
        if (snap_tid_last) lasts++;
      end
    end
    n_run++;
    if (beats !== 8 || lasts !== 2) begin
      n_fail++;
      $display("FAIL trunc_beats: beats=%0d lasts=%0d, required 8 and 2", beats, lasts);
    end
    n_run++;
    if (trunc_count !== 16'(t0 + 1)) begin
      n_fail++;
      $display("FAIL trunc_count: got %0d, required %0d", trunc_count, t0 + 1);
    end
    $display("[TB] truncation: trunc_count=%0d", trunc_count);
  endtask

  task automatic test_error_passthrough();
    int t0 = int'(trunc_count);
    int users = 0;
    add_frame(3, 3, 1);
    for (int c = 0; c < 200 && !quiet(); c++) begin
      step(100, 100);
      n_run++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL err_beat: got=%h required=%h", obs_vec, exp_vec);
      end
      if (snap_take && snap_user) users++;
    end
    n_run++;
    if (users !== 1 || trunc_count !== 16'(t0)) begin
      n_fail++;
      $display("FAIL err_flag: user beats=%0d trunc=%0d, required 1 and %0d", users, trunc_count, t0);
    end
    $display("[TB] error passthrough: %0d flagged beats", users);
  endtask

  task automatic test_reset_mid_frame();
    int first_tid = -1;
    int c = 0;
    add_frame(1, 4, 0);
    while (beat_n[1] != 1 && c < 50) begin
      step(100, 100);
      c++;
    end
    n_run++;
    if (beat_n[1] != 1) begin
      n_fail++;
      $display("FAIL rst_mid_start: port 1 first beat not taken within 50 cycles");
    end
    @(negedge aclk);
    areset_n = 1'b0;
    add_frame(0, 2, 0);
    vld_hold[0] = 1'b1;
    drive_ports();
    #1;
    n_run++;
    if (s_tready !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_mid_ready: s_tready=%b, required 0000", s_tready);
    end
    @(posedge aclk);
    reset_model();
    @(negedge aclk);
    areset_n = 1'b1;
    #1;
    n_run++;
    if (m_tvalid !== 1'b0 || trunc_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid_out: m_tvalid=%0b trunc=%0d, required 0 and 0", m_tvalid, trunc_count);
    end
    for (int k = 0; k < 200 && !quiet(); k++) begin
      step(100, 100);
      n_run++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rst_mid_beat: got=%h required=%h", obs_vec, exp_vec);
      end
      if (snap_take && first_tid < 0) first_tid = int'(snap_tid);
    end
    n_run++;
    if (first_tid !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_grant: first frame from port %0d, required 0", first_tid);
    end
    $display("[TB] reset mid-frame: first port %0d", first_tid);
  endtask

  task automatic test_random();
    int cyc = 0;
    for (int i = 0; i < 16; i++)
      add_frame(int'($urandom_range(3)), int'($urandom_range(7, 1)), 2);
    while (!quiet() && cyc < 4000) begin
      step(60, 70);
      cyc++;
      n_run++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rand_beat: cycle %0d got=%h required=%h", cyc, obs_vec, exp_vec);
      end
    end
    n_run++;
    if (!quiet()) begin
      n_fail++;
      $display("FAIL rand_drain: traffic still pending after %0d cycles", cyc);
    end
    n_run++;
    if (trunc_count !== 16'(exp_trunc)) begin
      n_fail++;
      $display("FAIL rand_trunc: got %0d, required %0d", trunc_count, exp_trunc);
    end
    $display("[TB] random: %0d cycles, trunc_count=%0d", cyc, trunc_count);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fairness();
    test_backpressure();
    test_truncation();
    test_error_passthrough();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
